// File: rtl/sprite_mem_arbiter.sv
// Round-robin arbiter sharing one single-port sprite BRAM among NUM_PROCS requesters, with an optional grant lock for atomic read-modify-write.
// Grants are combinational and one access is accepted per cycle; reads return BRAM_LATENCY cycles later, and requesters that are not granted simply hold req.
module sprite_mem_arbiter #(
  parameter int NUM_PROCS    = 4,
  parameter int MEMORY_SIZE  = 256,
  parameter int DATA_WIDTH   = 36,
  parameter int BRAM_LATENCY = 2,
  parameter int LOCK_MAX     = 16,
  localparam int AW = $clog2(MEMORY_SIZE),
  localparam int IW = (NUM_PROCS > 1) ? $clog2(NUM_PROCS) : 1,
  localparam int CW = $clog2(LOCK_MAX + 1)
) (
  input  logic                            pixel_clk_in,
  input  logic                            rst_in,
  input  logic [NUM_PROCS-1:0]            req,
  input  logic [NUM_PROCS-1:0]            we,
  input  logic [NUM_PROCS-1:0]            lock,
  input  logic [NUM_PROCS*AW-1:0]         addr,
  input  logic [NUM_PROCS*DATA_WIDTH-1:0] wdata,
  output logic [NUM_PROCS-1:0]            gnt,
  output logic [NUM_PROCS-1:0]            rvalid,
  output logic [DATA_WIDTH-1:0]           rdata,
  output logic                            lock_owner_valid,
  output logic [AW-1:0]                   mem_addr,
  output logic                            mem_we,
  output logic [DATA_WIDTH-1:0]           mem_din,
  input  logic [DATA_WIDTH-1:0]           mem_dout
);

  typedef enum logic {IDLE, LOCKED} state_t;

  typedef struct packed {
    logic          vld;
    logic [IW-1:0] idx;
  } tag_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [CW-1:0]   lock_cnt_q, lock_cnt_d;
  logic            acc;
  logic [IW-1:0]   acc_idx;
  logic [AW-1:0]   mem_addr_q;
  logic [DATA_WIDTH-1:0] mem_din_q;
  tag_t [BRAM_LATENCY-1:0] tag_q;

  function automatic logic [IW-1:0] ptr_inc(input logic [IW-1:0] p);
    return (int'(p) == NUM_PROCS - 1) ? '0 : p + IW'(1);
  endfunction

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    int j;
    j          = 0;
    state_d    = state_q;
    rr_ptr_d   = rr_ptr_q;
    owner_d    = owner_q;
    lock_cnt_d = lock_cnt_q;
    acc        = 1'b0;
    acc_idx    = '0;
    case (state_q)
      IDLE: begin
        // Walk offsets high to low so the requester closest to rr_ptr wins.
        for (int k = NUM_PROCS - 1; k >= 0; k--) begin
          j = int'(rr_ptr_q) + k;
          if (j >= NUM_PROCS) j = j - NUM_PROCS;
          if (req[j]) begin
            acc     = 1'b1;
            acc_idx = IW'(j);
          end
        end
        if (acc) begin
          rr_ptr_d = ptr_inc(acc_idx);
          if (lock[acc_idx] && LOCK_MAX > 1) begin
            state_d    = LOCKED;
            owner_d    = acc_idx;
            lock_cnt_d = CW'(1);
          end
        end
      end
      LOCKED: begin
        if (!req[owner_q]) begin
          state_d    = IDLE;
          rr_ptr_d   = ptr_inc(owner_q);
          lock_cnt_d = '0;
        end else begin
          acc     = 1'b1;
          acc_idx = owner_q;
          if (!lock[owner_q] || (lock_cnt_q + CW'(1) >= CW'(LOCK_MAX))) begin
            state_d    = IDLE;
            rr_ptr_d   = ptr_inc(owner_q);
            lock_cnt_d = '0;
          end else begin
            lock_cnt_d = lock_cnt_q + CW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Reset must silence the BRAM port immediately, not at the next edge.
    if (rst_in) acc = 1'b0;
    gnt = '0;
    if (acc) gnt[acc_idx] = 1'b1;
  end

  assign mem_we   = acc & we[acc_idx];
  assign mem_addr = acc ? addr[int'(acc_idx)*AW +: AW] : mem_addr_q;
  assign mem_din  = acc ? wdata[int'(acc_idx)*DATA_WIDTH +: DATA_WIDTH] : mem_din_q;

  always_ff @(posedge pixel_clk_in or posedge rst_in) begin
    if (rst_in) begin
      rr_ptr_q   <= '0;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      tag_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      mem_addr_q <= mem_addr;
      mem_din_q  <= mem_din;
      tag_q[0].vld <= acc & ~we[acc_idx];
      tag_q[0].idx <= acc_idx;
      for (int i = 1; i < BRAM_LATENCY; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  always_comb begin
    rvalid = '0;
    if (tag_q[BRAM_LATENCY-1].vld) rvalid[tag_q[BRAM_LATENCY-1].idx] = 1'b1;
  end

  assign rdata            = tag_q[BRAM_LATENCY-1].vld ? mem_dout : '0;
  assign lock_owner_valid = (state_q == LOCKED);

endmodule

// File: tb/tb_sprite_mem_arbiter.sv
// Scoreboard bench for sprite_mem_arbiter: behavioural arbiter/lock model, shadow memory and a 2-cycle BRAM model.
module tb_sprite_mem_arbiter;
  localparam int N = 4, AW = 8, DW = 36, LAT = 2, LMAX = 16, MEM = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0] req, we, lock, gnt, rvalid;
  logic [N*AW-1:0] addr;
  logic [N*DW-1:0] wdata;
  logic [DW-1:0] rdata, mem_din, mem_dout;
  logic [AW-1:0] mem_addr;
  logic lov, mem_we;

  sprite_mem_arbiter #(.NUM_PROCS(N), .MEMORY_SIZE(MEM), .DATA_WIDTH(DW),
                       .BRAM_LATENCY(LAT), .LOCK_MAX(LMAX)) dut (
    .pixel_clk_in(clk), .rst_in(rst), .req(req), .we(we), .lock(lock),
    .addr(addr), .wdata(wdata), .gnt(gnt), .rvalid(rvalid), .rdata(rdata),
    .lock_owner_valid(lov), .mem_addr(mem_addr), .mem_we(mem_we),
    .mem_din(mem_din), .mem_dout(mem_dout));

  always #5 clk = ~clk;

  // Write-first BRAM model with two cycles of read latency.
  logic [DW-1:0] bram [MEM];
  logic [DW-1:0] dpipe [LAT];
  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < MEM; i++) bram[i] <= '0;
    end else if (mem_we) begin
      bram[mem_addr] <= mem_din;
    end
    dpipe[0] <= mem_we ? mem_din : bram[mem_addr];
    dpipe[1] <= dpipe[0];
  end
  assign mem_dout = dpipe[1];

  typedef struct {
    int            due;
    int            idx;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          sb[$];
  logic [DW-1:0] shadow [MEM];
  int            n_checks = 0, n_fail = 0, cyc = 0;
  int            m_ptr = 0, m_owner = 0, m_cnt = 0;
  bit            m_locked = 1'b0;
  logic [N-1:0]  obs_gnt;
  logic          obs_lov;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic set_req(input int i, input bit r, input bit w, input bit l,
                         input int a, input logic [DW-1:0] d);
    req[i] = r; we[i] = w; lock[i] = l;
    addr[i*AW +: AW] = AW'(a);
    wdata[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    req = '0; we = '0; lock = '0;
  endtask

  task automatic model_reset();
    sb.delete();
    m_ptr = 0; m_owner = 0; m_cnt = 0; m_locked = 1'b0;
    for (int i = 0; i < MEM; i++) shadow[i] = '0;
  endtask

  // One clock cycle: compare at the falling edge, then advance the model.
  task automatic step();
    logic [N-1:0]  eg;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
    int            g;
    exp_t          e;
    @(negedge clk);
    eg = '0;
    g  = -1;
    if (m_locked) begin
      if (req[m_owner]) g = m_owner;
    end else begin
      for (int k = 0; k < N; k++)
        if (g < 0 && req[(m_ptr + k) % N]) g = (m_ptr + k) % N;
    end
    if (g >= 0) eg[g] = 1'b1;
    obs_gnt = gnt;
    obs_lov = lov;
    check("gnt", gnt, eg);
    check("lock_owner_valid", lov, m_locked);
    if (sb.size() > 0 && sb[0].due == cyc) begin
      e = sb.pop_front();
      check("rvalid", rvalid, 64'(1) << e.idx);
      check("rdata", rdata, e.data);
    end else begin
      check("rvalid_idle", rvalid, 0);
    end
    if (g >= 0) begin
      a = addr[g*AW +: AW];
      d = wdata[g*DW +: DW];
      check("mem_we", mem_we, we[g]);
      check("mem_addr", mem_addr, a);
      if (we[g]) begin
        check("mem_din", mem_din, d);
        shadow[a] = d;
      end else begin
        e.due = cyc + LAT; e.idx = g; e.data = shadow[a];
        sb.push_back(e);
      end
    end else begin
      check("mem_we_idle", mem_we, 0);
    end
    if (m_locked) begin
      if (!req[m_owner] || !lock[m_owner] || m_cnt + 1 == LMAX) begin
        m_locked = 1'b0;
        m_ptr    = (m_owner + 1) % N;
      end else begin
        m_cnt++;
      end
    end else if (g >= 0) begin
      m_ptr = (g + 1) % N;
      if (lock[g]) begin
        m_locked = 1'b1; m_owner = g; m_cnt = 1;
      end
    end
    @(posedge clk);
    cyc++;
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n_p1;
    req = '0; we = '0; lock = '0; addr = '0; wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    req = '1; we = '1;
    @(negedge clk);
    check("rst_gnt", gnt, 0);
    check("rst_rvalid", rvalid, 0);
    check("rst_lov", lov, 0);
    check("rst_mem_we", mem_we, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_din", mem_din, 0);
    check("rst_rdata", rdata, 0);
    clear_req();
    @(posedge clk); #1;
    rst = 1'b0;

    // Write then read back through requester 0.
    set_req(0, 1, 1, 0, 5, 36'h123); step();
    set_req(0, 1, 0, 0, 5, '0);      step();
    clear_req(); repeat (3) step();

    // Move the pointer to 0, then all four read together.
    set_req(3, 1, 1, 0, 9, 36'hABC); step();
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, (i % 2 == 0) ? 5 : 9, '0);
    for (int k = 0; k < 8; k++) begin
      step();
      check("rr_order", obs_gnt, 64'(1) << (k % N));
    end
    clear_req(); repeat (2) step();

    // Lock held by P2 while P0/P1 wait.
    set_req(1, 1, 0, 0, 5, '0); step();
    clear_req();
    set_req(0, 1, 0, 0, 5, '0); set_req(1, 1, 0, 0, 9, '0);
    set_req(2, 1, 0, 1, 9, '0); step();
    check("lock_first", obs_gnt, 4'b0100); check("lock_lov_a", obs_lov, 0);
    step();
    check("lock_stall", obs_gnt, 4'b0100); check("lock_lov_b", obs_lov, 1);
    set_req(2, 1, 1, 0, 20, 36'h5A5); step();
    check("lock_last", obs_gnt, 4'b0100); check("lock_lov_c", obs_lov, 1);
    set_req(2, 0, 0, 0, 0, '0); set_req(3, 1, 0, 0, 20, '0); step();
    check("lock_after", obs_gnt, 4'b1000); check("lock_lov_d", obs_lov, 0);
    clear_req(); repeat (2) step();

    // Lock timeout: P1 keeps lock asserted, P2 waits.
    set_req(1, 1, 0, 1, 5, '0); set_req(2, 1, 0, 0, 9, '0);
    n_p1 = 0;
    for (int k = 0; k < 40; k++) begin
      step();
      if (obs_gnt == 4'b0010) n_p1++;
      else break;
    end
    check("timeout_accepts", n_p1, LMAX);
    check("timeout_next_gnt", obs_gnt, 4'b0100);
    check("timeout_lov", obs_lov, 0);
    clear_req(); repeat (2) step();

    // Owner drops req for a cycle.
    set_req(3, 1, 0, 1, 9, '0); step();
    check("drop_lock_gnt", obs_gnt, 4'b1000);
    set_req(3, 0, 0, 0, 0, '0); set_req(0, 1, 0, 0, 5, '0); set_req(1, 1, 0, 0, 9, '0);
    step();
    check("drop_stall", obs_gnt, 4'b0000); check("drop_lov", obs_lov, 1);
    step();
    check("drop_next", obs_gnt, 4'b0001); check("drop_lov_off", obs_lov, 0);
    clear_req(); repeat (2) step();

    // Random traffic against the model.
    for (int k = 0; k < 60; k++) begin
      req  = N'($urandom_range(0, 15));
      we   = N'($urandom_range(0, 15));
      lock = N'($urandom_range(0, 15) & $urandom_range(0, 15));
      for (int i = 0; i < N; i++) begin
        addr[i*AW +: AW]  = AW'($urandom_range(0, 15));
        wdata[i*DW +: DW] = DW'({$urandom(), $urandom()});
      end
      step();
    end
    clear_req(); repeat (20) step();

    // Async reset with two reads in flight.
    set_req(0, 1, 0, 0, 5, '0); set_req(1, 1, 0, 0, 9, '0);
    step(); step();
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 0, 7, 36'h777);
    #1;
    check("rvalid_pre_rst", rvalid, (sb.size() > 0) ? (64'(1) << sb[0].idx) : 64'hDEAD);
    rst = 1'b1;
    #1;
    check("rst_async_gnt", gnt, 0);
    check("rst_async_rvalid", rvalid, 0);
    check("rst_async_mem_we", mem_we, 0);
    check("rst_async_rdata", rdata, 0);
    model_reset();
    clear_req();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (4) step();
    for (int i = 0; i < N; i++) set_req(i, 1, 0, 0, 5, '0);
    step();
    check("first_gnt_after_rst", obs_gnt, 4'b0001);
    clear_req(); repeat (4) step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
